// File: rtl/elu_lookup_ctrl_if.sv
// elu_lookup_ctrl_if: sample-in / activation-out streams plus the
// ELU ROM read port, bundled for the elu_lookup_ctrl front end.
interface elu_lookup_ctrl_if #(
    parameter int IN_WIDTH = 16,
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 11
);
    logic                       s_valid;
    logic                       s_ready;
    logic signed [IN_WIDTH-1:0] s_data;
    logic                       m_valid;
    logic                       m_ready;
    logic signed [DWIDTH-1:0]   m_data;
    logic                       m_sat;
    logic [AWIDTH-1:0]          rom_addr;
    logic [DWIDTH-1:0]          rom_q;

    // Environment side: upstream producer, downstream consumer, ROM.
    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        output rom_q,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_sat,
        input  rom_addr
    );

    // Controller side.
    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        input  rom_q,
        output s_ready,
        output m_valid,
        output m_data,
        output m_sat,
        output rom_addr
    );
endinterface

// File: rtl/elu_lookup_ctrl.sv
// elu_lookup_ctrl: clamps signed samples to ELU ROM addresses and streams
// looked-up activations out. Optional macro ELU_POS_BYPASS_EN skips the ROM for x >= 0.
module elu_lookup_ctrl #(
    parameter int IN_WIDTH = 16,
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 11,
    parameter int WORDS    = 1597,
    parameter int ZERO_IDX = 1596
) (
    input logic              clk,
    input logic              rst,
    elu_lookup_ctrl_if.slave bus
);

    localparam int IW2 = IN_WIDTH + 2;

    localparam logic signed [IW2-1:0] LP_ZERO   = IW2'(ZERO_IDX);
    localparam logic signed [IW2-1:0] LP_LAST   = IW2'(WORDS - 1);
    localparam logic [AWIDTH-1:0]     LP_LAST_A = AWIDTH'(WORDS - 1);

    logic                  r_v1;
    logic                  r_v2;
    logic [AWIDTH-1:0]     r_addr1;
    logic [AWIDTH-1:0]     r_addr2;
    logic                  r_sat1;
    logic                  r_sat2;

    logic                  w_adv1;
    logic                  w_adv2;
    logic                  w_accept;
    logic signed [IW2-1:0] w_idx;
    logic [AWIDTH-1:0]     w_addr;
    logic                  w_tsat;
    logic                  w_sat1;
    logic [DWIDTH-1:0]     w_data;

    // Stage 2 frees up on a downstream take; stage 1 frees up behind it.
    assign w_adv2   = !r_v2 || bus.m_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign w_accept = bus.s_valid && w_adv1;

    // Widen by two bits so x + ZERO_IDX never wraps before clamping.
    assign w_idx = $signed({{2{bus.s_data[IN_WIDTH-1]}}, bus.s_data})
                 + LP_ZERO;

    // Clamp the table index into [0, WORDS-1].
    always_comb begin
        w_addr = w_idx[AWIDTH-1:0];
        w_tsat = 1'b0;
        if (w_idx[IW2-1]) begin
            w_addr = '0;
            w_tsat = 1'b1;
        end else if (w_idx > LP_LAST) begin
            w_addr = LP_LAST_A;
            w_tsat = 1'b1;
        end
    end

`ifdef ELU_POS_BYPASS_EN
    localparam logic signed [IN_WIDTH-1:0] LP_BMAX =
        IN_WIDTH'((1 << (DWIDTH - 1)) - 1);

    logic              r_byp1;
    logic              r_byp2;
    logic [DWIDTH-1:0] r_bval1;
    logic [DWIDTH-1:0] r_bval2;
    logic              w_byp;
    logic              w_bsat;
    logic [DWIDTH-1:0] w_bval;

    // Non-negative samples pass through, clamped to the positive range.
    always_comb begin
        w_byp  = !bus.s_data[IN_WIDTH-1];
        w_bsat = w_byp && (bus.s_data > LP_BMAX);
        w_bval = w_bsat ? LP_BMAX[DWIDTH-1:0]
                        : bus.s_data[DWIDTH-1:0];
    end

    assign w_sat1 = w_byp ? w_bsat : w_tsat;

    // Bypass flag and value travel alongside the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp1  <= 1'b0;
            r_bval1 <= '0;
            r_byp2  <= 1'b0;
            r_bval2 <= '0;
        end else begin
            if (w_adv2) begin
                r_byp2  <= r_byp1;
                r_bval2 <= r_bval1;
            end
            if (w_accept) begin
                r_byp1  <= w_byp;
                r_bval1 <= w_bval;
            end
        end
    end

    assign w_data = !r_v2  ? '0 :
                    r_byp2 ? r_bval2 : bus.rom_q;
`else
    assign w_sat1 = w_tsat;
    assign w_data = r_v2 ? bus.rom_q : '0;
`endif

    // Two-stage pipe: stage 2 holds the sample whose ROM word is on rom_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_addr1 <= '0;
            r_sat1  <= 1'b0;
            r_v2    <= 1'b0;
            r_addr2 <= '0;
            r_sat2  <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_v2    <= r_v1;
                r_addr2 <= r_addr1;
                r_sat2  <= r_sat1;
            end
            if (w_adv1) begin
                r_v1 <= w_accept;
            end
            if (w_accept) begin
                r_addr1 <= w_addr;
                r_sat1  <= w_sat1;
            end
        end
    end

    // Re-issue addr2 while stalled so rom_q keeps showing its word.
    assign bus.rom_addr = (r_v2 && !bus.m_ready) ? r_addr2 : r_addr1;

    assign bus.s_ready = w_adv1;
    assign bus.m_valid = r_v2;
    assign bus.m_sat   = r_v2 && r_sat2;
    assign bus.m_data  = w_data;

endmodule

// File: tb/tb_elu_lookup_ctrl.sv
// tb_elu_lookup_ctrl: directed vector table plus stall, streaming
// and mid-stream reset sequences against a behavioural ROM.
module tb_elu_lookup_ctrl;

    localparam int IN_WIDTH = 16;
    localparam int DWIDTH   = 8;
    localparam int AWIDTH   = 11;
    localparam int WORDS    = 1597;
    localparam int ZERO_IDX = 1596;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    elu_lookup_ctrl_if #(
        .IN_WIDTH(IN_WIDTH),
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH)
    ) bus ();

    elu_lookup_ctrl #(
        .IN_WIDTH(IN_WIDTH),
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH),
        .WORDS   (WORDS),
        .ZERO_IDX(ZERO_IDX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [7:0] mem [0:WORDS-1];

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 8'(i) ^ 8'h5A;
    end

    always @(posedge clk) bus.rom_q <= mem[bus.rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic int ref_addr(input int x);
        int idx;
        idx = x + ZERO_IDX;
        if (idx < 0) return 0;
        if (idx > WORDS - 1) return WORDS - 1;
        return idx;
    endfunction

    function automatic logic ref_sat(input int x);
        int idx;
`ifdef ELU_POS_BYPASS_EN
        if (x >= 0) return x > 127;
`endif
        idx = x + ZERO_IDX;
        return (idx < 0) || (idx > WORDS - 1);
    endfunction

    function automatic logic [7:0] ref_data(input int x);
`ifdef ELU_POS_BYPASS_EN
        if (x >= 0) return (x > 127) ? 8'd127 : 8'(x);
`endif
        return mem[ref_addr(x)];
    endfunction

    typedef struct {
        int         x;
        int         addr;
        logic       sat;
        logic       byp;
        logic [7:0] bval;
    } vec_t;

    vec_t vt[$];

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int occ;
        int k;
        logic stalled_prev;
        logic [8:0] prev;
        logic acc;
        logic dlv;
        int xs [100];
        logic [7:0] exp_d;

        vt.push_back('{-1,     1595, 1'b0, 1'b0, 8'd0});
        vt.push_back('{-2000,  0,    1'b1, 1'b0, 8'd0});
        vt.push_back('{-1596,  0,    1'b0, 1'b0, 8'd0});
        vt.push_back('{-1597,  0,    1'b1, 1'b0, 8'd0});
        vt.push_back('{-800,   796,  1'b0, 1'b0, 8'd0});
        vt.push_back('{-32768, 0,    1'b1, 1'b0, 8'd0});
`ifdef ELU_POS_BYPASS_EN
        vt.push_back('{0,      1596, 1'b0, 1'b1, 8'd0});
        vt.push_back('{5,      1596, 1'b0, 1'b1, 8'd5});
        vt.push_back('{127,    1596, 1'b0, 1'b1, 8'd127});
        vt.push_back('{128,    1596, 1'b1, 1'b1, 8'd127});
        vt.push_back('{300,    1596, 1'b1, 1'b1, 8'd127});
        vt.push_back('{32767,  1596, 1'b1, 1'b1, 8'd127});
`else
        vt.push_back('{0,      1596, 1'b0, 1'b0, 8'd0});
        vt.push_back('{1,      1596, 1'b1, 1'b0, 8'd0});
        vt.push_back('{300,    1596, 1'b1, 1'b0, 8'd0});
        vt.push_back('{32767,  1596, 1'b1, 1'b0, 8'd0});
`endif

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        #12;
        check("rst_s_ready",  32'(bus.s_ready), 1);
        check("rst_m_valid",  32'(bus.m_valid), 0);
        check("rst_m_data",   {24'd0, bus.m_data}, 0);
        check("rst_m_sat",    32'(bus.m_sat), 0);
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(vt[i].x);
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.s_valid = 1'b0;
            #1;
            check("vec_rom_addr", 32'(bus.rom_addr), 32'(vt[i].addr));
            @(negedge clk);
            #1;
            exp_d = vt[i].byp ? vt[i].bval : mem[vt[i].addr];
            check("vec_m_valid", 32'(bus.m_valid), 1);
            check("vec_m_data",  {24'd0, bus.m_data}, {24'd0, exp_d});
            check("vec_m_sat",   32'(bus.m_sat), 32'(vt[i].sat));
        end
        @(negedge clk);
        #1;
        check("vec_drained", 32'(bus.m_valid), 0);

        sent = 0;
        got  = 0;
        occ  = 0;
        stalled_prev = 1'b0;
        prev = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.m_ready = !(c >= 2 && c <= 6);
            bus.s_valid = (sent < 8);
            bus.s_data  = 16'(-10 + sent);
            #1;
            check("burst_s_ready", 32'(bus.s_ready),
                  32'(!(occ == 2 && !bus.m_ready)));
            if (stalled_prev)
                check("burst_hold", {23'd0, bus.m_sat, bus.m_data},
                      {23'd0, prev});
            if (bus.m_valid && bus.m_ready) begin
                check("burst_data", {24'd0, bus.m_data},
                      {24'd0, mem[1586 + got]});
                check("burst_sat", 32'(bus.m_sat), 0);
                got++;
            end
            stalled_prev = bus.m_valid && !bus.m_ready;
            prev = {bus.m_sat, bus.m_data};
            acc  = bus.s_valid && bus.s_ready;
            dlv  = bus.m_valid && bus.m_ready;
            if (acc) sent++;
            occ = occ + int'(acc) - int'(dlv);
        end
        check("burst_count", 32'(got), 8);
        bus.s_valid = 1'b0;

        for (int i = 0; i < 100; i++)
            xs[i] = int'($urandom_range(0, 5000)) - 2500;
        xs[0] = -32768;
        xs[1] = 32767;
        xs[2] = 0;
        k = 0;
        for (int c = 0; c < 105; c++) begin
            @(negedge clk);
            bus.m_ready = 1'b1;
            bus.s_valid = (c < 100);
            bus.s_data  = (c < 100) ? 16'(xs[c]) : 16'd0;
            #1;
            check("stream_s_ready", 32'(bus.s_ready), 1);
            check("stream_m_valid", 32'(bus.m_valid),
                  32'(c >= 2 && c <= 101));
            if (bus.m_valid && k < 100) begin
                check("stream_data", {24'd0, bus.m_data},
                      {24'd0, ref_data(xs[k])});
                check("stream_sat", 32'(bus.m_sat), 32'(ref_sat(xs[k])));
                k++;
            end
        end
        check("stream_count", 32'(k), 100);
        bus.s_valid = 1'b0;

        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = -16'sd5;
        @(negedge clk);
        bus.s_data  = -16'sd6;
        @(negedge clk);
        bus.s_valid = 1'b0;
        #1;
        check("full_s_ready", 32'(bus.s_ready), 0);
        check("full_m_valid", 32'(bus.m_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_m_valid",  32'(bus.m_valid), 0);
        check("arst_s_ready",  32'(bus.s_ready), 1);
        check("arst_m_data",   {24'd0, bus.m_data}, 0);
        check("arst_m_sat",    32'(bus.m_sat), 0);
        check("arst_rom_addr", 32'(bus.rom_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_idle", 32'(bus.m_valid), 0);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = -16'sd7;
        @(negedge clk);
        bus.s_valid = 1'b0;
        #1;
        check("post_rst_addr", 32'(bus.rom_addr), 1589);
        check("post_rst_early", 32'(bus.m_valid), 0);
        @(negedge clk);
        #1;
        check("post_rst_valid", 32'(bus.m_valid), 1);
        check("post_rst_data", {24'd0, bus.m_data}, {24'd0, mem[1589]});
        @(negedge clk);
        #1;
        check("post_rst_single", 32'(bus.m_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
